// File: rtl/commit_arbiter.sv
// commit_arbiter: buffers ALU/load/store/branch completions in per-source FIFOs and serialises them onto one completion port.
// Optional COMMIT_ARB_PERF_EN adds per-source grant counters and a stall counter.
module commit_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PHY_WIDTH  = 6,
    parameter int ROB_WIDTH  = 5,
    parameter int Q_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alu_valid,
    input  logic [ROB_WIDTH-1:0]  alu_rob_id,
    input  logic [PHY_WIDTH-1:0]  alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  load_valid,
    input  logic [ROB_WIDTH-1:0]  load_rob_id,
    input  logic [PHY_WIDTH-1:0]  load_rd,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  store_valid,
    input  logic [ROB_WIDTH-1:0]  store_rob_id,
    input  logic                  br_valid,
    input  logic                  br_is_jump,
    input  logic [ROB_WIDTH-1:0]  br_rob_id,
    input  logic [PHY_WIDTH-1:0]  br_rd,
    input  logic [ADDR_WIDTH-1:0] br_nextPC,
    input  logic [ADDR_WIDTH-1:0] br_target,
    input  logic [ADDR_WIDTH-1:0] br_update_pc,
    input  logic                  br_mispredict,
    input  logic                  br_taken,
    output logic                  alu_ready,
    output logic                  load_ready,
    output logic                  store_ready,
    output logic                  br_ready,
    input  logic                  cpl_ready,
    output logic                  cpl_valid,
    output logic [1:0]            cpl_src,
    output logic [ROB_WIDTH-1:0]  cpl_rob_id,
    output logic                  cpl_rd_we,
    output logic [PHY_WIDTH-1:0]  cpl_rd,
    output logic [DATA_WIDTH-1:0] cpl_data,
    output logic                  cpl_mispredict,
    output logic                  cpl_taken,
    output logic                  cpl_is_jump,
    output logic [ADDR_WIDTH-1:0] cpl_target,
    output logic [ADDR_WIDTH-1:0] cpl_update_pc,
    output logic                  overflow
`ifdef COMMIT_ARB_PERF_EN
    ,
    output logic [31:0]           perf_grant_cnt [0:3],
    output logic [31:0]           perf_stall_cnt
`endif
);
    localparam int AW = $clog2(Q_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(Q_DEPTH);

    typedef struct packed {
        logic [ROB_WIDTH-1:0]  rob_id;
        logic [PHY_WIDTH-1:0]  rd;
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] target;
        logic [ADDR_WIDTH-1:0] update_pc;
        logic                  is_jump;
        logic                  mispredict;
        logic                  taken;
    } entry_t;

    entry_t        mem [4][Q_DEPTH];
    entry_t        in_entry [4];
    entry_t        head;
    logic [AW-1:0] wptr [4];
    logic [AW-1:0] rptr [4];
    logic [AW:0]   cnt [4];
    logic [3:0]    in_valid, full, ne, push, pop;
    logic [1:0]    rr_ptr, c1, c2, rr_sel, src;
    logic          fire;

    always_comb begin
        in_valid = {br_valid, store_valid, load_valid, alu_valid};
        for (int i = 0; i < 4; i++) in_entry[i] = '0;
        in_entry[0].rob_id     = alu_rob_id;
        in_entry[0].rd         = alu_rd;
        in_entry[0].data       = alu_data;
        in_entry[1].rob_id     = load_rob_id;
        in_entry[1].rd         = load_rd;
        in_entry[1].data       = load_data;
        in_entry[2].rob_id     = store_rob_id;
        in_entry[3].rob_id     = br_rob_id;
        in_entry[3].rd         = br_rd;
        in_entry[3].data       = DATA_WIDTH'(br_nextPC);
        in_entry[3].target     = br_target;
        in_entry[3].update_pc  = br_update_pc;
        in_entry[3].is_jump    = br_is_jump;
        in_entry[3].mispredict = br_mispredict;
        in_entry[3].taken      = br_taken;
    end

    for (genvar g = 0; g < 4; g++) begin : g_flags
        assign full[g] = cnt[g] == FULL_CNT;
        assign ne[g]   = cnt[g] != '0;
    end

    assign {br_ready, store_ready, load_ready, alu_ready} = ~full;

    // Round-robin search order among ALU/LOAD/STORE, starting at rr_ptr
    assign c1     = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
    assign c2     = (rr_ptr == 2'd0) ? 2'd2 : rr_ptr - 2'd1;
    assign rr_sel = ne[rr_ptr] ? rr_ptr : ne[c1] ? c1 : c2;
    assign src    = ne[3] ? 2'd3 : rr_sel;
    assign head   = mem[src][rptr[src]];

    assign cpl_valid = !flush && |ne;
    assign fire      = cpl_valid && cpl_ready;
    assign push      = in_valid & ~full & {4{!flush}};
    assign pop       = fire ? 4'b0001 << src : 4'b0000;

    assign cpl_src        = cpl_valid ? src : 2'd0;
    assign cpl_rob_id     = cpl_valid ? head.rob_id : '0;
    assign cpl_rd         = cpl_valid ? head.rd : '0;
    assign cpl_data       = cpl_valid ? head.data : '0;
    assign cpl_target     = cpl_valid ? head.target : '0;
    assign cpl_update_pc  = cpl_valid ? head.update_pc : '0;
    assign cpl_is_jump    = cpl_valid && head.is_jump;
    assign cpl_mispredict = cpl_valid && head.mispredict;
    assign cpl_taken      = cpl_valid && head.taken;
    assign cpl_rd_we      = cpl_valid && src != 2'd2 && head.rd != '0 && (src != 2'd3 || head.is_jump);

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) if (push[i]) mem[i][wptr[i]] <= in_entry[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            rr_ptr   <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (|(in_valid & full)) overflow <= 1'b1;
            if (flush) begin
                for (int i = 0; i < 4; i++) begin
                    wptr[i] <= '0;
                    rptr[i] <= '0;
                    cnt[i]  <= '0;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (push[i]) wptr[i] <= wptr[i] + AW'(1);
                    if (pop[i]) rptr[i] <= rptr[i] + AW'(1);
                    cnt[i] <= cnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
                end
                if (fire && src != 2'd3) rr_ptr <= (src == 2'd2) ? 2'd0 : src + 2'd1;
            end
        end
    end

`ifdef COMMIT_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) perf_grant_cnt[i] <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fire) perf_grant_cnt[src] <= perf_grant_cnt[src] + 32'd1;
            if (cpl_valid && !cpl_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_commit_arbiter.sv
// tb_commit_arbiter: directed scenario tests for commit_arbiter with hand-computed expectations.
module tb_commit_arbiter;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic        alu_valid, load_valid, store_valid, br_valid;
    logic [4:0]  alu_rob_id, load_rob_id, store_rob_id, br_rob_id;
    logic [5:0]  alu_rd, load_rd, br_rd;
    logic [31:0] alu_data, load_data;
    logic        br_is_jump, br_mispredict, br_taken;
    logic [31:0] br_nextPC, br_target, br_update_pc;
    logic        alu_ready, load_ready, store_ready, br_ready;
    logic        cpl_ready, cpl_valid, cpl_rd_we, cpl_mispredict, cpl_taken, cpl_is_jump, overflow;
    logic [1:0]  cpl_src;
    logic [4:0]  cpl_rob_id;
    logic [5:0]  cpl_rd;
    logic [31:0] cpl_data, cpl_target, cpl_update_pc;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    commit_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_rd(alu_rd), .alu_data(alu_data),
        .load_valid(load_valid), .load_rob_id(load_rob_id), .load_rd(load_rd), .load_data(load_data),
        .store_valid(store_valid), .store_rob_id(store_rob_id),
        .br_valid(br_valid), .br_is_jump(br_is_jump), .br_rob_id(br_rob_id), .br_rd(br_rd),
        .br_nextPC(br_nextPC), .br_target(br_target), .br_update_pc(br_update_pc),
        .br_mispredict(br_mispredict), .br_taken(br_taken),
        .alu_ready(alu_ready), .load_ready(load_ready), .store_ready(store_ready), .br_ready(br_ready),
        .cpl_ready(cpl_ready), .cpl_valid(cpl_valid), .cpl_src(cpl_src), .cpl_rob_id(cpl_rob_id),
        .cpl_rd_we(cpl_rd_we), .cpl_rd(cpl_rd), .cpl_data(cpl_data),
        .cpl_mispredict(cpl_mispredict), .cpl_taken(cpl_taken), .cpl_is_jump(cpl_is_jump),
        .cpl_target(cpl_target), .cpl_update_pc(cpl_update_pc), .overflow(overflow)
    );

    task automatic clear_inputs();
        flush = 0;
        alu_valid = 0; alu_rob_id = '0; alu_rd = '0; alu_data = '0;
        load_valid = 0; load_rob_id = '0; load_rd = '0; load_data = '0;
        store_valid = 0; store_rob_id = '0;
        br_valid = 0; br_is_jump = 0; br_rob_id = '0; br_rd = '0;
        br_nextPC = '0; br_target = '0; br_update_pc = '0; br_mispredict = 0; br_taken = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        clear_inputs();
        cpl_ready = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        cpl_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (cpl_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", cpl_valid); end
        checks++; if ({alu_ready, load_ready, store_ready, br_ready} !== 4'hF) begin failures++; $display("FAIL reset_ready got=%b exp=1111", {alu_ready, load_ready, store_ready, br_ready}); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if ({cpl_rob_id, cpl_data, cpl_src} !== '0) begin failures++; $display("FAIL reset_fields got=%h exp=0", {cpl_rob_id, cpl_data, cpl_src}); end
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (cpl_valid !== 1'b0) begin failures++; $display("FAIL reset_idle got=%b exp=0", cpl_valid); end
        cpl_ready = 0;
        alu_valid = 1; alu_rob_id = 5'd9; alu_rd = 6'd1;
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (cpl_valid !== 1'b1) begin failures++; $display("FAIL midreset_pre got=%b exp=1", cpl_valid); end
        rst = 0;
        #1;
        checks++; if (cpl_valid !== 1'b0) begin failures++; $display("FAIL midreset_async got=%b exp=0", cpl_valid); end
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_single_alu();
        do_reset();
        @(negedge clk);
        alu_valid = 1; alu_rob_id = 5'd3; alu_rd = 6'd5; alu_data = 32'hDEADBEEF;
        #1;
        checks++; if (cpl_valid !== 1'b0) begin failures++; $display("FAIL alu_latency got=%b exp=0", cpl_valid); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if ({cpl_valid, cpl_src, cpl_rob_id, cpl_rd_we, cpl_rd} !== {1'b1, 2'd0, 5'd3, 1'b1, 6'd5}) begin failures++; $display("FAIL alu_fields got=%h exp=%h", {cpl_valid, cpl_src, cpl_rob_id, cpl_rd_we, cpl_rd}, {1'b1, 2'd0, 5'd3, 1'b1, 6'd5}); end
        checks++; if (cpl_data !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_data got=%h exp=deadbeef", cpl_data); end
        @(negedge clk);
        #1;
        checks++; if (cpl_valid !== 1'b0) begin failures++; $display("FAIL alu_drain got=%b exp=0", cpl_valid); end
    endtask

    task automatic test_all_sources();
        int es[4] = '{3, 0, 1, 2};
        int er[4] = '{4, 1, 2, 3};
        do_reset();
        @(negedge clk);
        alu_valid = 1; alu_rob_id = 5'd1; alu_rd = 6'd2; alu_data = 32'h11;
        load_valid = 1; load_rob_id = 5'd2; load_rd = 6'd3; load_data = 32'h22;
        store_valid = 1; store_rob_id = 5'd3;
        br_valid = 1; br_rob_id = 5'd4; br_mispredict = 1; br_taken = 1; br_target = 32'h300; br_update_pc = 32'h80;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            clear_inputs();
            #1;
            checks++; if ({cpl_valid, cpl_src, cpl_rob_id} !== {1'b1, 2'(es[k]), 5'(er[k])}) begin failures++; $display("FAIL prio_grant%0d got=%h exp=%h", k, {cpl_valid, cpl_src, cpl_rob_id}, {1'b1, 2'(es[k]), 5'(er[k])}); end
            if (k == 0) begin
                checks++; if ({cpl_mispredict, cpl_taken, cpl_target, cpl_update_pc} !== {1'b1, 1'b1, 32'h300, 32'h80}) begin failures++; $display("FAIL prio_brfields got=%h exp=%h", {cpl_mispredict, cpl_taken, cpl_target, cpl_update_pc}, {1'b1, 1'b1, 32'h300, 32'h80}); end
            end
        end
        @(negedge clk);
        #1;
        checks++; if (cpl_valid !== 1'b0) begin failures++; $display("FAIL prio_drain got=%b exp=0", cpl_valid); end
        alu_valid = 1; alu_rob_id = 5'd5;
        load_valid = 1; load_rob_id = 5'd6;
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if ({cpl_src, cpl_rob_id} !== {2'd0, 5'd5}) begin failures++; $display("FAIL rr_wrap_alu got=%h exp=%h", {cpl_src, cpl_rob_id}, {2'd0, 5'd5}); end
        @(negedge clk);
        #1;
        checks++; if ({cpl_src, cpl_rob_id} !== {2'd1, 5'd6}) begin failures++; $display("FAIL rr_wrap_load got=%h exp=%h", {cpl_src, cpl_rob_id}, {2'd1, 5'd6}); end
    endtask

    task automatic test_full_fifo();
        do_reset();
        cpl_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (i == 1 || i == 3) begin
                checks++; if ({alu_ready, cpl_valid, cpl_rob_id} !== {1'b1, 1'b1, 5'd0}) begin failures++; $display("FAIL full_fill%0d got=%h exp=%h", i, {alu_ready, cpl_valid, cpl_rob_id}, {1'b1, 1'b1, 5'd0}); end
            end
            if (i == 4) begin
                checks++; if ({alu_ready, overflow} !== 2'b00) begin failures++; $display("FAIL full_ready got=%b exp=00", {alu_ready, overflow}); end
            end
            alu_valid = 1; alu_rob_id = 5'(i); alu_rd = 6'd7;
        end
        @(negedge clk);
        clear_inputs();
        cpl_ready = 1;
        #1;
        checks++; if ({overflow, cpl_valid, cpl_rob_id} !== {1'b1, 1'b1, 5'd0}) begin failures++; $display("FAIL full_overflow got=%h exp=%h", {overflow, cpl_valid, cpl_rob_id}, {1'b1, 1'b1, 5'd0}); end
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++; if ({cpl_valid, cpl_rob_id} !== {1'b1, 5'(i)}) begin failures++; $display("FAIL full_order%0d got=%h exp=%h", i, {cpl_valid, cpl_rob_id}, {1'b1, 5'(i)}); end
        end
        @(negedge clk);
        #1;
        checks++; if ({cpl_valid, alu_ready, overflow} !== 3'b011) begin failures++; $display("FAIL full_drop got=%b exp=011", {cpl_valid, alu_ready, overflow}); end
    endtask

    task automatic test_flush();
        do_reset();
        cpl_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            load_valid = 1; load_rob_id = 5'(20 + i); load_rd = 6'd4;
        end
        @(negedge clk);
        clear_inputs();
        flush = 1;
        alu_valid = 1; alu_rob_id = 5'd12; alu_rd = 6'd2;
        #1;
        checks++; if (cpl_valid !== 1'b0) begin failures++; $display("FAIL flush_cycle got=%b exp=0", cpl_valid); end
        @(negedge clk);
        clear_inputs();
        cpl_ready = 1;
        #1;
        checks++; if ({cpl_valid, load_ready, overflow} !== 3'b010) begin failures++; $display("FAIL flush_empty got=%b exp=010", {cpl_valid, load_ready, overflow}); end
        @(negedge clk);
        #1;
        checks++; if (cpl_valid !== 1'b0) begin failures++; $display("FAIL flush_after got=%b exp=0", cpl_valid); end
    endtask

    task automatic test_rd_we();
        do_reset();
        @(negedge clk);
        alu_valid = 1; alu_rob_id = 5'd7; alu_rd = 6'd0; alu_data = 32'h5;
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if ({cpl_valid, cpl_src, cpl_rd_we} !== {1'b1, 2'd0, 1'b0}) begin failures++; $display("FAIL rdwe_alu0 got=%h exp=%h", {cpl_valid, cpl_src, cpl_rd_we}, {1'b1, 2'd0, 1'b0}); end
        br_valid = 1; br_is_jump = 1; br_rob_id = 5'd8; br_rd = 6'd1; br_nextPC = 32'h104;
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if ({cpl_src, cpl_rob_id, cpl_rd_we, cpl_is_jump, cpl_data} !== {2'd3, 5'd8, 1'b1, 1'b1, 32'h104}) begin failures++; $display("FAIL rdwe_jump got=%h exp=%h", {cpl_src, cpl_rob_id, cpl_rd_we, cpl_is_jump, cpl_data}, {2'd3, 5'd8, 1'b1, 1'b1, 32'h104}); end
        br_valid = 1; br_rob_id = 5'd9; br_rd = 6'd3; br_mispredict = 1; br_taken = 1; br_target = 32'h200;
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if ({cpl_src, cpl_rob_id, cpl_rd_we, cpl_mispredict, cpl_target} !== {2'd3, 5'd9, 1'b0, 1'b1, 32'h200}) begin failures++; $display("FAIL rdwe_branch got=%h exp=%h", {cpl_src, cpl_rob_id, cpl_rd_we, cpl_mispredict, cpl_target}, {2'd3, 5'd9, 1'b0, 1'b1, 32'h200}); end
        store_valid = 1; store_rob_id = 5'd15;
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if ({cpl_valid, cpl_src, cpl_rob_id, cpl_rd_we} !== {1'b1, 2'd2, 5'd15, 1'b0}) begin failures++; $display("FAIL rdwe_store got=%h exp=%h", {cpl_valid, cpl_src, cpl_rob_id, cpl_rd_we}, {1'b1, 2'd2, 5'd15, 1'b0}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (i > 0) begin
                checks++; if ({cpl_valid, cpl_rob_id} !== {1'b1, 5'(9 + i)}) begin failures++; $display("FAIL b2b_%0d got=%h exp=%h", i, {cpl_valid, cpl_rob_id}, {1'b1, 5'(9 + i)}); end
            end
            alu_valid = 1; alu_rob_id = 5'(10 + i); alu_rd = 6'd3;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if ({cpl_valid, cpl_rob_id} !== {1'b1, 5'd13}) begin failures++; $display("FAIL b2b_last got=%h exp=%h", {cpl_valid, cpl_rob_id}, {1'b1, 5'd13}); end
        @(negedge clk);
        #1;
        checks++; if (cpl_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", cpl_valid); end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_all_sources();
        test_full_fifo();
        test_flush();
        test_rd_we();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
